// File: rtl/square_and_multiply.sv
// Modular exponentiation out = m^e mod n by LSB-first square-and-multiply.
// Each modular product is an interleaved shift-add loop, one multiplier bit per cycle.
module square_and_multiply #(
    parameter int unsigned BUS_WIDTH     = 256,
    parameter int unsigned COUNTER_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] m,
    input  logic [BUS_WIDTH-1:0] e,
    input  logic [BUS_WIDTH-1:0] n,
    input  logic                 ready,
    output logic [BUS_WIDTH-1:0] out,
    output logic                 valid
);

    localparam int unsigned AW = BUS_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                   state;
    logic [BUS_WIDTH-1:0]     e_q;
    logic [BUS_WIDTH-1:0]     n_q;
    logic [BUS_WIDTH-1:0]     res_q;
    logic [BUS_WIDTH-1:0]     base_q;
    logic [BUS_WIDTH-1:0]     mbits_q;
    logic [AW-1:0]            pm_q;
    logic [AW-1:0]            ps_q;
    logic [COUNTER_WIDTH-1:0] mul_cnt;
    logic [COUNTER_WIDTH-1:0] exp_cnt;
    logic                     fin_q;

    logic [AW-1:0]            pm_nxt_c;
    logic [AW-1:0]            ps_nxt_c;
    logic                     mul_last_c;
    logic                     exp_last_c;

    // One interleaved step: P = 2P mod n, then P = P + b mod n when the bit is set.
    function automatic logic [AW-1:0] mod_step(input logic [AW-1:0] p,
                                               input logic          bit_set,
                                               input logic [AW-1:0] b,
                                               input logic [AW-1:0] md);
        logic [AW-1:0] t;
        t = p << 1;
        if (t >= md) t = t - md;
        if (bit_set) begin
            t = t + b;
            if (t >= md) t = t - md;
        end
        return t;
    endfunction

    // Multiply (base*result) and square (base*base) share the base bit stream.
    always_comb begin
        pm_nxt_c   = mod_step(pm_q, mbits_q[BUS_WIDTH-1], AW'(res_q), AW'(n_q));
        ps_nxt_c   = mod_step(ps_q, mbits_q[BUS_WIDTH-1], AW'(base_q), AW'(n_q));
        mul_last_c = (mul_cnt == COUNTER_WIDTH'(BUS_WIDTH - 1));
        exp_last_c = (exp_cnt == COUNTER_WIDTH'(BUS_WIDTH - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            out     <= '0;
            valid   <= 1'b0;
            e_q     <= '0;
            n_q     <= '0;
            res_q   <= '0;
            base_q  <= '0;
            mbits_q <= '0;
            pm_q    <= '0;
            ps_q    <= '0;
            mul_cnt <= '0;
            exp_cnt <= '0;
            fin_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (ready) begin
                        e_q     <= e;
                        n_q     <= n;
                        // n of 0 or 1 forces a zero result throughout.
                        res_q   <= (n > BUS_WIDTH'(1)) ? BUS_WIDTH'(1) : '0;
                        base_q  <= m;
                        mbits_q <= m;
                        pm_q    <= '0;
                        ps_q    <= '0;
                        mul_cnt <= '0;
                        exp_cnt <= '0;
                        fin_q   <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (fin_q) begin
                        out   <= res_q;
                        valid <= 1'b1;
                        fin_q <= 1'b0;
                        state <= DONE;
                    end else if (mul_last_c) begin
                        if (e_q[0]) res_q <= BUS_WIDTH'(pm_nxt_c);
                        base_q  <= BUS_WIDTH'(ps_nxt_c);
                        mbits_q <= BUS_WIDTH'(ps_nxt_c);
                        pm_q    <= '0;
                        ps_q    <= '0;
                        mul_cnt <= '0;
                        e_q     <= e_q >> 1;
                        exp_cnt <= exp_cnt + COUNTER_WIDTH'(1);
                        if (exp_last_c) fin_q <= 1'b1;
                    end else begin
                        pm_q    <= pm_nxt_c;
                        ps_q    <= ps_nxt_c;
                        mbits_q <= mbits_q << 1;
                        mul_cnt <= mul_cnt + COUNTER_WIDTH'(1);
                    end
                end
                DONE: begin
                    if (!ready) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_square_and_multiply.sv
// Scoreboard bench: a 16-bit instance for directed/random traffic and a
// 256-bit instance for the full-width reference vector, run concurrently.
module tb_square_and_multiply;

    localparam int unsigned SW  = 16;
    localparam int unsigned SCW = 4;
    localparam int unsigned BW  = 256;
    localparam int unsigned BCW = 8;

    typedef struct {
        logic [255:0] val;
        int           start;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    exp_t sq[$];
    exp_t bq[$];

    logic          s_reset, s_ready, s_valid;
    logic [SW-1:0] s_m, s_e, s_n, s_out;
    logic          b_reset, b_ready, b_valid;
    logic [BW-1:0] b_m, b_e, b_n, b_out;

    square_and_multiply #(.BUS_WIDTH(SW), .COUNTER_WIDTH(SCW)) u_small (
        .clk(clk), .reset(s_reset), .m(s_m), .e(s_e), .n(s_n),
        .ready(s_ready), .out(s_out), .valid(s_valid)
    );

    square_and_multiply #(.BUS_WIDTH(BW), .COUNTER_WIDTH(BCW)) u_big (
        .clk(clk), .reset(b_reset), .m(b_m), .e(b_e), .n(b_n),
        .ready(b_ready), .out(b_out), .valid(b_valid)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic logic [SW-1:0] model_small(input logic [SW-1:0] m, input logic [SW-1:0] e,
                                                  input logic [SW-1:0] n);
        longint unsigned r, b, nn;
        if (n == 0) return '0;
        nn = 64'(n);
        r  = 64'd1 % nn;
        b  = 64'(m) % nn;
        for (int i = 0; i < int'(SW); i++) begin
            if (e[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return SW'(r);
    endfunction

    function automatic logic [BW-1:0] model_big(input logic [BW-1:0] m, input logic [BW-1:0] e,
                                                input logic [BW-1:0] n);
        logic [511:0] r, b, nn;
        if (n == 0) return '0;
        nn = 512'(n);
        r  = 512'd1 % nn;
        b  = 512'(m) % nn;
        for (int i = 0; i < int'(BW); i++) begin
            if (e[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return BW'(r);
    endfunction

    // Monitors: pop one expectation on every rising edge of valid.
    logic s_vprev = 1'b0;
    always @(negedge clk) begin
        exp_t x;
        if (s_valid && !s_vprev) begin
            if (sq.size() == 0) begin
                total++; bad++;
                $display("FAIL s_unexpected_valid got=1 expected=0");
            end else begin
                x = sq.pop_front();
                check("s_out", 256'(s_out), x.val);
                check("s_latency", 256'(cyc - x.start), 256'(SW * SW + 1));
            end
        end
        s_vprev = s_valid;
    end

    logic b_vprev = 1'b0;
    always @(negedge clk) begin
        exp_t x;
        if (b_valid && !b_vprev) begin
            if (bq.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_valid got=1 expected=0");
            end else begin
                x = bq.pop_front();
                check("b_out", b_out, x.val);
                check("b_latency", 256'(cyc - x.start), 256'(BW * BW + 1));
            end
        end
        b_vprev = b_valid;
    end

    task automatic s_wait_valid();
        for (int k = 0; k < int'(SW * SW) + 8 && !s_valid; k++) @(negedge clk);
        check("s_valid_timeout", 256'(s_valid), 256'(1));
    endtask

    // swap=1 drives the alternate operand set one cycle after start; otherwise random garbage.
    task automatic s_op(input logic [SW-1:0] m, input logic [SW-1:0] e, input logic [SW-1:0] n,
                        input logic [SW-1:0] expv, input bit hold, input bit swap);
        @(negedge clk);
        s_m = m; s_e = e; s_n = n; s_ready = 1'b1;
        sq.push_back('{256'(expv), cyc + 1});
        @(negedge clk);
        if (!hold) s_ready = 1'b0;
        @(negedge clk);
        if (swap) begin
            s_m = 16'd2; s_e = 16'd10; s_n = 16'd1000;
        end else begin
            s_m = 16'($urandom); s_e = 16'($urandom); s_n = 16'($urandom);
        end
        s_wait_valid();
        if (hold) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("s_hold_valid", 256'(s_valid), 256'(1));
                check("s_hold_out", 256'(s_out), 256'(expv));
            end
            s_ready = 1'b0;
        end
        @(negedge clk);
        check("s_valid_drop", 256'(s_valid), 256'(0));
        check("s_out_keep", 256'(s_out), 256'(expv));
    endtask

    task automatic s_async_reset();
        @(negedge clk);
        #2 s_reset = 1'b0;
        #1;
        check("s_rst_valid", 256'(s_valid), 256'(0));
        check("s_rst_out", 256'(s_out), 256'(0));
        @(negedge clk);
        s_reset = 1'b1;
    endtask

    task automatic run_small();
        logic [SW-1:0] m, e, n;
        s_m = '0; s_e = '0; s_n = '0; s_ready = 1'b0; s_reset = 1'b0;
        #1;
        check("s_reset_valid", 256'(s_valid), 256'(0));
        check("s_reset_out", 256'(s_out), 256'(0));
        @(negedge clk);
        s_reset = 1'b1;

        s_op(16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 1'b0);
        s_op(16'd7, 16'd0, 16'd11, 16'd1, 1'b1, 1'b0);
        s_op(16'd5, 16'd3, 16'd1, 16'd0, 1'b0, 1'b0);
        s_op(16'd5, 16'd3, 16'd0, 16'd0, 1'b0, 1'b0);
        s_op(16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 1'b1);

        // Abort mid-computation, then restart from scratch.
        @(negedge clk);
        s_m = 16'd4; s_e = 16'd13; s_n = 16'd497; s_ready = 1'b1;
        @(negedge clk);
        s_ready = 1'b0;
        repeat (100) @(negedge clk);
        s_async_reset();
        sq.delete();
        s_op(16'd2, 16'd10, 16'd1000, 16'd24, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            n = 16'($urandom_range(2, 65535));
            if (i < 3) n = 16'($urandom_range(2, 20));
            m = 16'($urandom_range(0, int'(n) - 1));
            e = (i == 4) ? 16'd0 : 16'($urandom);
            s_op(m, e, n, model_small(m, e, n), i[0], 1'b0);
        end
        s_op(16'hfffe, 16'hffff, 16'hffff, model_small(16'hfffe, 16'hffff, 16'hffff), 1'b1, 1'b0);
    endtask

    task automatic run_big();
        logic [BW-1:0] m, e, n, golden;
        m = 256'd2134314354651231;
        e = 256'd1423145646468123513547564;
        n = 256'd1 << 255;
        golden = 256'h5e01be74314ce13db217697fee88a7b77be7b3d44f679908b1e623eac4e9781;
        b_m = '0; b_e = '0; b_n = '0; b_ready = 1'b0; b_reset = 1'b0;
        @(negedge clk);
        b_reset = 1'b1;
        @(negedge clk);
        b_m = m; b_e = e; b_n = n; b_ready = 1'b1;
        bq.push_back('{golden, cyc + 1});
        @(negedge clk);
        b_m = '1; b_e = '1; b_n = '1;
        for (int k = 0; k < int'(BW * BW) + 8 && !b_valid; k++) @(negedge clk);
        check("b_valid_timeout", 256'(b_valid), 256'(1));
        check("b_model", b_out, model_big(m, e, n));
        repeat (2) @(negedge clk);
        check("b_hold_valid", 256'(b_valid), 256'(1));
        b_ready = 1'b0;
        @(negedge clk);
        check("b_valid_drop", 256'(b_valid), 256'(0));
        check("b_out_keep", b_out, golden);
    endtask

    initial begin
        fork
            run_small();
            run_big();
        join
        repeat (3) @(negedge clk);
        check("s_queue_empty", 256'(sq.size()), 256'(0));
        check("b_queue_empty", 256'(bq.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
